spi_master_clkgen_burst: RTL and testbench
==========================================

Name: spi_master_clkgen_burst

Overview:
Parametrised next-generation SPI master clock generator. It produces a bounded burst of SCK cycles with programmable divider width, CPOL/CPHA mode and bit count. It also produces per-edge sample/shift strobes and busy/done handshakes. It sits between the APB register block and the SPI shift datapath, replacing the free-running enable-gated generator.

Parameters:
DIV_W, 8, width of divider / half-period target
BITS_W, 6, width of bit-count field; max burst = 2**BITS_W-1 bits

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
clk_div  in  DIV_W  half-period target; half period = clk_div+1 clk cycles
clk_div_valid  in  1  load clk_div into target register (honoured only in IDLE)
cpol  in  1  SCK idle level
cpha  in  1  0: sample leading/shift trailing; 1: shift leading/sample trailing
num_bits  in  BITS_W  SCK cycles per burst
start  in  1  single-cycle burst request
abort  in  1  terminate burst immediately
spi_clk  out  1  SCK
spi_lead  out  1  1-cycle pulse coincident with SCK leading edge
spi_trail  out  1  1-cycle pulse coincident with SCK trailing edge
sample_stb  out  1  receive-sample strobe
shift_stb  out  1  transmit-shift strobe
busy  out  1  burst in progress (RUN or TAIL)
done  out  1  1-cycle pulse at normal burst completion

Behaviour:
- Reset values: spi_clk=0, all strobes 0, busy=0, done=0, target=0, counter=0, edge count=0, state IDLE.
- Target register: in IDLE, clk_div_valid loads clk_div; ignored while busy. start in the same cycle as clk_div_valid uses the new value.
- In IDLE, cpol/cpha are registered every cycle and spi_clk = registered cpol (one-cycle latency). On start acceptance they freeze until return to IDLE.
- States:
  - IDLE: start && num_bits!=0 -> RUN; counter=0; edge count=0; latch num_bits; busy=1 the next cycle. start with num_bits==0 is ignored: no busy, no done.
  - RUN: counter increments each cycle. When counter==target: counter<=0, spi_clk toggles, edge count increments. The pulse is driven combinationally in the toggle cycle: spi_lead if current spi_clk==cpol, else spi_trail. The first edge occurs target+1 cycles after busy rises. After edge 2*num_bits (spi_clk back at cpol) -> TAIL.
  - TAIL: hold SCK idle for one further half period (target+1 cycles), then -> IDLE with done=1 for that one cycle. busy drops in the same cycle done pulses.
- Strobes:
  - cpha=0: sample_stb=spi_lead; shift_stb=spi_trail, except suppressed on the final trailing edge.
  - cpha=1: shift_stb=spi_lead; sample_stb=spi_trail.
  - Exactly num_bits sample_stb pulses per burst.
- Edge counter width BITS_W+1; no wrap within a legal burst.
- abort (any state, priority over start): next cycle state=IDLE, spi_clk=cpol, counter/edge count cleared, no done, no pending strobe.
- start while busy: ignored.
- target=0: SCK toggles every cycle (period 2 clk); strobes remain single-cycle and may occur back-to-back.
- Async reset mid-burst: all outputs return immediately to reset values. spi_clk goes to 0 regardless of cpol until the first post-reset clock edge.

Decomposition:
- Package spi_clkgen_pkg: state enum (IDLE, RUN, TAIL), default DIV_W/BITS_W localparams, and an edge-type helper function mapping (cpol, cpha, lead/trail) to sample/shift.
- One sub-module is natural: spi_halfperiod_cnt (DIV_W counter with target compare and terminal-count pulse), reused by RUN and TAIL.

Test Plan:
- Mode 0, clk_div=3, num_bits=8, start -> 16 SCK edges, each half period 4 cycles; 8 sample_stb on rising edges; 7 shift_stb; done 4 cycles after last edge; busy high 68 cycles.
- Mode 3 (cpol=1, cpha=1), clk_div=0, num_bits=2 -> SCK idles 1, toggles every cycle (1-0-1-0-1); shift on falling edges, sample on rising edges; 2 each; done one cycle after the tail.
- clk_div_valid with value 5 while busy (burst running at target 2) -> current burst keeps 3-cycle half periods; the next burst uses 3 unless reloaded in IDLE.
- abort on cycle 10 of a mode-0 div=3 8-bit burst -> next cycle spi_clk=0, busy=0, no done, no further strobes; a new start works normally.
- start with num_bits=0, and start while busy -> no state change, no done.
- rst asserted mid-RUN with cpol=1 -> spi_clk=0, busy=0 asynchronously; after release spi_clk=1 one cycle later.

Source files
------------

// File: rtl/spi_clkgen_pkg.sv
// Shared definitions for the burst SPI clock generator: state encoding,
// default widths and the edge-to-strobe mapping.
package spi_clkgen_pkg;

    localparam int DIV_W_DEF  = 8;
    localparam int BITS_W_DEF = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;

    // cpol only moves SCK levels; which edge samples depends on cpha alone.
    function automatic logic is_sample_edge(input logic cpha, input logic lead);
        return cpha ? !lead : lead;
    endfunction

endpackage

// File: rtl/spi_halfperiod_cnt.sv
// Half-period counter: counts 0..target while enabled and flags the
// terminal count combinationally, wrapping to zero on it.
module spi_halfperiod_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] target,
    output logic             tc
);

    logic [DIV_W-1:0] r_cnt;

    assign tc = en && (r_cnt == target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= tc ? '0 : r_cnt + DIV_W'(1);
    end

endmodule

// File: rtl/spi_master_clkgen_burst.sv
// Bounded-burst SPI SCK generator with CPOL/CPHA handling, per-edge
// sample/shift strobes and busy/done handshakes.
module spi_master_clkgen_burst
    import spi_clkgen_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int BITS_W = BITS_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              clk_div_valid,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [BITS_W-1:0] num_bits,
    input  logic              start,
    input  logic              abort,
    output logic              spi_clk,
    output logic              spi_lead,
    output logic              spi_trail,
    output logic              sample_stb,
    output logic              shift_stb,
    output logic              busy,
    output logic              done
);

    logic [1:0]        r_state;
    logic [DIV_W-1:0]  r_target;
    logic [BITS_W-1:0] r_nbits;
    logic [BITS_W:0]   r_edges;
    logic              r_sck;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_done;

    logic              w_idle;
    logic              w_active;
    logic              w_tc;
    logic              w_edge;
    logic              w_lead;
    logic              w_last;
    logic              w_sample_edge;
    logic [BITS_W:0]   w_last_idx;

    assign w_idle     = (r_state == ST_IDLE);
    // abort freezes the counter in the same cycle so no strobe leaks out
    assign w_active   = !w_idle && !abort;
    assign w_last_idx = {r_nbits, 1'b0} - (BITS_W+1)'(1);

    spi_halfperiod_cnt #(.DIV_W(DIV_W)) u_hp (
        .clk    (clk),
        .rst    (rst),
        .clr    (!w_active),
        .en     (w_active),
        .target (r_target),
        .tc     (w_tc)
    );

    assign w_edge        = w_tc && (r_state == ST_RUN);
    assign w_lead        = w_edge && (r_sck == r_cpol);
    assign w_last        = w_edge && (r_edges == w_last_idx);
    assign w_sample_edge = is_sample_edge(r_cpha, w_lead);

    assign spi_clk    = r_sck;
    assign spi_lead   = w_lead;
    assign spi_trail  = w_edge && !w_lead;
    assign sample_stb = w_edge && w_sample_edge;
    // the closing trailing edge of a cpha=0 burst has no next bit to shift
    assign shift_stb  = w_edge && !w_sample_edge && !w_last;
    assign busy       = !w_idle;
    assign done       = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_nbits  <= '0;
            r_edges  <= '0;
            r_sck    <= 1'b0;
            r_cpol   <= 1'b0;
            r_cpha   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && !w_idle) begin
                r_state <= ST_IDLE;
                r_sck   <= r_cpol;
                r_edges <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cpol <= cpol;
                        r_cpha <= cpha;
                        r_sck  <= cpol;
                        if (clk_div_valid)
                            r_target <= clk_div;
                        if (start && !abort && (num_bits != '0)) begin
                            r_state <= ST_RUN;
                            r_nbits <= num_bits;
                            r_edges <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (w_tc) begin
                            r_sck   <= ~r_sck;
                            r_edges <= r_edges + (BITS_W+1)'(1);
                            if (w_last)
                                r_state <= ST_TAIL;
                        end
                    end
                    ST_TAIL: begin
                        if (w_tc) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_master_clkgen_burst.sv
// Directed bench for spi_master_clkgen_burst: a burst-level timing model
// is checked every cycle, plus hand-computed per-burst totals.
module tb_spi_master_clkgen_burst;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] clk_div;
    logic       clk_div_valid;
    logic       cpol;
    logic       cpha;
    logic [5:0] num_bits;
    logic       start;
    logic       abort;
    logic       spi_clk, spi_lead, spi_trail, sample_stb, shift_stb, busy, done;

    int total = 0;
    int bad   = 0;

    // burst model: t counts cycles since busy rose, H = half period
    bit   m_busy = 0;
    int   m_t, m_H, m_N, m_tgt = 0;
    logic m_cpol, m_cpha;
    logic m_sck_idle = 1'b0;
    logic m_done = 1'b0;

    int   c_busy = 0, c_samp = 0, c_shift = 0, c_lead = 0, c_trail = 0, c_done = 0;
    logic [31:0] sck_hist = '0;

    spi_master_clkgen_burst #(.DIV_W(8), .BITS_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_div       (clk_div),
        .clk_div_valid (clk_div_valid),
        .cpol          (cpol),
        .cpha          (cpha),
        .num_bits      (num_bits),
        .start         (start),
        .abort         (abort),
        .spi_clk       (spi_clk),
        .spi_lead      (spi_lead),
        .spi_trail     (spi_trail),
        .sample_stb    (sample_stb),
        .shift_stb     (shift_stb),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string n, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s t=%0t got=%b exp=%b", n, $time, a, e);
        end
    endtask

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", n, $time, a, e);
        end
    endtask

    task automatic compare_cycle();
        logic e_sck, e_lead, e_trail, e_samp, e_shift, e_busy, e_done;
        bit   edge_now;
        int   k;
        e_sck = 1'b0; e_lead = 1'b0; e_trail = 1'b0; e_samp = 1'b0;
        e_shift = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (rst) begin
            e_sck = 1'b0;
        end else if (m_busy) begin
            e_busy   = 1'b1;
            edge_now = 0;
            k        = (m_t + 1) / m_H;
            if (m_t < 2 * m_N * m_H) begin
                e_sck    = m_cpol ^ (((m_t / m_H) % 2) == 1);
                edge_now = (((m_t + 1) % m_H) == 0) && !abort;
            end else begin
                e_sck = m_cpol;
            end
            e_lead  = edge_now && (k % 2 == 1);
            e_trail = edge_now && (k % 2 == 0);
            e_samp  = m_cpha ? e_trail : e_lead;
            e_shift = m_cpha ? e_lead : (e_trail && (k != 2 * m_N));
        end else begin
            e_sck  = m_sck_idle;
            e_done = m_done;
        end
        cmp("spi_clk", spi_clk, e_sck);
        cmp("spi_lead", spi_lead, e_lead);
        cmp("spi_trail", spi_trail, e_trail);
        cmp("sample_stb", sample_stb, e_samp);
        cmp("shift_stb", shift_stb, e_shift);
        cmp("busy", busy, e_busy);
        cmp("done", done, e_done);
        if (!rst) begin
            if (busy) begin
                c_busy++;
                sck_hist = {sck_hist[30:0], spi_clk};
            end
            if (sample_stb) c_samp++;
            if (shift_stb)  c_shift++;
            if (spi_lead)   c_lead++;
            if (spi_trail)  c_trail++;
            if (done)       c_done++;
        end
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (rst) begin
            m_busy = 0; m_sck_idle = 1'b0; m_tgt = 0;
        end else if (m_busy) begin
            if (abort) begin
                m_busy = 0; m_sck_idle = m_cpol;
            end else begin
                m_t++;
                if (m_t == (2 * m_N + 1) * m_H) begin
                    m_busy = 0; m_done = 1'b1; m_sck_idle = m_cpol;
                end
            end
        end else begin
            if (clk_div_valid) m_tgt = int'(clk_div);
            m_sck_idle = cpol;
            if (start && !abort && num_bits != 0) begin
                m_busy = 1; m_t = 0; m_H = m_tgt + 1; m_N = int'(num_bits);
                m_cpol = cpol; m_cpha = cpha;
            end
        end
    endtask

    // one cycle: check at negedge, advance model at posedge, resume 1 after it
    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic launch(input logic [7:0] div, input logic ld, input logic [5:0] nb);
        clk_div = div; clk_div_valid = ld; num_bits = nb; start = 1'b1;
        tick();
        start = 1'b0; clk_div_valid = 1'b0;
    endtask

    int s_busy, s_samp, s_shift, s_lead, s_trail, s_done;
    task automatic snap();
        s_busy = c_busy; s_samp = c_samp; s_shift = c_shift;
        s_lead = c_lead; s_trail = c_trail; s_done = c_done;
    endtask

    initial begin
        rst = 1'b1; clk_div = '0; clk_div_valid = 1'b0; cpol = 1'b0; cpha = 1'b0;
        num_bits = '0; start = 1'b0; abort = 1'b0;
        #3;
        cmp("rst_spi_clk", spi_clk, 1'b0);
        cmp("rst_busy", busy, 1'b0);
        cmp("rst_done", done, 1'b0);
        ticks(2);
        rst = 1'b0;
        ticks(2);

        // mode 0, div 3, 8 bits: 68 busy cycles, 8 samples, 7 shifts
        snap();
        launch(8'd3, 1'b1, 6'd8);
        ticks(72);
        chk("m0_busy_cycles", c_busy - s_busy, 68);
        chk("m0_samples", c_samp - s_samp, 8);
        chk("m0_shifts", c_shift - s_shift, 7);
        chk("m0_leads", c_lead - s_lead, 8);
        chk("m0_trails", c_trail - s_trail, 8);
        chk("m0_done", c_done - s_done, 1);

        // mode 3, div 0, 2 bits: SCK 1-0-1-0-1 while busy
        cpol = 1'b1; cpha = 1'b1;
        ticks(2);
        snap();
        launch(8'd0, 1'b1, 6'd2);
        ticks(8);
        chk("m3_busy_cycles", c_busy - s_busy, 5);
        chk("m3_sck_pattern", int'(sck_hist[4:0]), 5'b10101);
        chk("m3_samples", c_samp - s_samp, 2);
        chk("m3_shifts", c_shift - s_shift, 2);
        chk("m3_done", c_done - s_done, 1);

        // divider reload while busy is ignored for this and the next burst
        cpol = 1'b0; cpha = 1'b0;
        ticks(2);
        snap();
        launch(8'd2, 1'b1, 6'd3);
        ticks(4);
        clk_div = 8'd5; clk_div_valid = 1'b1;
        tick();
        clk_div_valid = 1'b0;
        ticks(25);
        chk("div_busy_cycles", c_busy - s_busy, 21);
        snap();
        launch(8'd7, 1'b0, 6'd1);
        ticks(12);
        chk("div_next_busy", c_busy - s_busy, 9);
        chk("div_next_samples", c_samp - s_samp, 1);
        chk("div_next_shifts", c_shift - s_shift, 0);

        // abort in busy cycle 10 of a mode-0 div-3 burst
        snap();
        launch(8'd3, 1'b1, 6'd8);
        ticks(10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cmp("abort_busy", busy, 1'b0);
        cmp("abort_spi_clk", spi_clk, 1'b0);
        chk("abort_samples", c_samp - s_samp, 1);
        chk("abort_shifts", c_shift - s_shift, 1);
        snap();
        ticks(20);
        chk("abort_no_strobes", (c_samp - s_samp) + (c_shift - s_shift), 0);
        chk("abort_no_done", c_done - s_done, 0);
        snap();
        launch(8'd3, 1'b0, 6'd2);
        ticks(25);
        chk("post_abort_busy", c_busy - s_busy, 20);
        chk("post_abort_samples", c_samp - s_samp, 2);
        chk("post_abort_done", c_done - s_done, 1);

        // zero-length start and start while busy are both ignored
        snap();
        launch(8'd0, 1'b0, 6'd0);
        ticks(5);
        chk("zero_bits_busy", c_busy - s_busy, 0);
        chk("zero_bits_done", c_done - s_done, 0);
        snap();
        launch(8'd0, 1'b1, 6'd1);
        tick();
        launch(8'd0, 1'b0, 6'd5);
        ticks(6);
        chk("restart_busy", c_busy - s_busy, 3);
        chk("restart_done", c_done - s_done, 1);

        // async reset mid-run with cpol=1
        cpol = 1'b1;
        ticks(2);
        launch(8'd3, 1'b1, 6'd4);
        ticks(9);
        #2 rst = 1'b1;
        #1;
        cmp("async_rst_spi_clk", spi_clk, 1'b0);
        cmp("async_rst_busy", busy, 1'b0);
        ticks(2);
        rst = 1'b0;
        cmp("rst_release_spi_clk0", spi_clk, 1'b0);
        tick();
        cmp("rst_release_spi_clk1", spi_clk, 1'b1);
        ticks(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
